inv_key_sched_ctrl: RTL and testbench

- Sequencer for the single-step inverse AES-128 key-expansion datapath.
- Loads the final (round-NR) round key, then iterates the step combinationally once per accepted output. It supplies the current key and the matching rcon word, and captures the returned previous-round key.
- Emits round keys NR down to 0 on a valid/ready stream for the decryption round pipeline.

---
 rtl/inv_key_sched_ctrl.sv | 115 +++++++++++
 tb/tb_inv_key_sched_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_key_sched_ctrl.sv
// Purpose : sequences the inverse AES-128 key step, emitting round keys NR down to 0.
// Latency : first round key valid the cycle after an accepted start; one key per cycle when unstalled.
// Backpressure: rk_ready low holds rk_key/rk_round; rk_valid never depends on rk_ready.
module inv_key_sched_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [0:127] key_in,
    output logic [0:127] gen_key,
    output logic [31:0]  gen_rcon,
    input  logic [0:127] gen_ko,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [0:127] rk_key,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Legal NR is 1..10, so four bits always hold the first round index.
    localparam logic [3:0] NR_L = 4'(NR);

    state_t       state_q, state_d;
    logic [0:127] key_q, key_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         done_q, done_d;
    logic         fire;

    // AES round constant for the step that produces the key of round (r-1) from round r.
    function automatic logic [7:0] rc_of(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Outputs are straight register decodes, so nothing here looks at rk_ready.
    assign gen_key  = key_q;
    assign rk_key   = key_q;
    assign rk_round = rnd_q;
    assign gen_rcon = {rc_of(rnd_q), 24'h000000};
    assign rk_valid = (state_q == EMIT);
    assign busy     = (state_q == EMIT);
    assign done     = done_q;
    assign fire     = (state_q == EMIT) && rk_ready;

    // Next-state: abort beats start and fire; a fire on round 0 ends the schedule with a done pulse.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            rnd_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        key_d   = key_in;
                        rnd_d   = NR_L;
                        state_d = EMIT;
                    end
                end
                EMIT: begin
                    if (fire) begin
                        if (rnd_q != 4'd0) begin
                            key_d = gen_ko;
                            rnd_d = rnd_q - 4'd1;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers; reset clears everything so all outputs read zero immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            rnd_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_inv_key_sched_ctrl.sv
// Purpose : directed + randomized check of inv_key_sched_ctrl against a forward AES key expansion model.
// Latency : checks first key one cycle after start and done one cycle after the round-0 handshake.
// Backpressure: drives rk_ready always-high, random, and with a long stall, expecting held outputs.
module tb_inv_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, abort, rk_ready;
    logic [127:0] key_in, gen_key, gen_ko, rk_key;
    logic [31:0]  gen_rcon;
    logic         rk_valid, busy, done;
    logic [3:0]   rk_round;

    logic         start1, abort1, rk_ready1;
    logic [127:0] key_in1, gen_key1, gen_ko1, rk_key1;
    logic [31:0]  gen_rcon1;
    logic         rk_valid1, busy1, done1;
    logic [3:0]   rk_round1;

    int           errors = 0;
    int           checks = 0;
    logic [7:0]   sbox_t [0:255];
    logic [127:0] exp_k  [0:10];

    localparam logic [127:0] FIPS_K0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    inv_key_sched_ctrl #(.NR(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key_in(key_in),
        .gen_key(gen_key), .gen_rcon(gen_rcon), .gen_ko(gen_ko),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_key(rk_key), .rk_round(rk_round),
        .busy(busy), .done(done)
    );

    inv_key_sched_ctrl #(.NR(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .key_in(key_in1),
        .gen_key(gen_key1), .gen_rcon(gen_rcon1), .gen_ko(gen_ko1),
        .rk_valid(rk_valid1), .rk_ready(rk_ready1), .rk_key(rk_key1), .rk_round(rk_round1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // Round constant from its definition: x^(r-1) in GF(2^8); none below round 1.
    function automatic logic [7:0] rc_model(input int r);
        logic [7:0] rc = 8'h01;
        if (r < 1 || r > 10) return 8'h00;
        for (int j = 1; j < r; j++) rc = xt(rc);
        return rc;
    endfunction

    // Step datapath: rebuild the previous round key from the current one (NR=10 instance).
    always_comb begin
        logic [31:0] w0, w1, w2, w3, p3, t;
        w0 = gen_key[127:96]; w1 = gen_key[95:64]; w2 = gen_key[63:32]; w3 = gen_key[31:0];
        p3 = w3 ^ w2;
        t  = {p3[23:0], p3[31:24]};
        t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        gen_ko = {w0 ^ t ^ gen_rcon, w1 ^ w0, w2 ^ w1, p3};
    end

    // Same step datapath for the NR=1 instance.
    always_comb begin
        logic [31:0] w0, w1, w2, w3, p3, t;
        w0 = gen_key1[127:96]; w1 = gen_key1[95:64]; w2 = gen_key1[63:32]; w3 = gen_key1[31:0];
        p3 = w3 ^ w2;
        t  = {p3[23:0], p3[31:24]};
        t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        gen_ko1 = {w0 ^ t ^ gen_rcon1, w1 ^ w0, w2 ^ w1, p3};
    end

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] b;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
            b = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox_t[x] = b;
        end
    endtask

    // Forward FIPS-197 expansion from the round-0 key; the DUT must reproduce it backwards.
    task automatic expand(input logic [127:0] k0);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One schedule on the NR=10 instance. mode 0: ready held high; mode 1: random ready with an
    // 8-cycle stall at round 5. start_at/abort_at/reset_at pick a round for the disturbance (-1 = none).
    task automatic run(input logic [127:0] k0, input int mode, input int start_at,
                       input int abort_at, input int reset_at);
        int r = 10;
        int cyc = 0;
        int stall = 0;
        bit injected = 1'b0;
        bit fired;
        expand(k0);
        start = 1'b1; key_in = exp_k[10];
        step();
        start = 1'b0;
        chk("first_valid", 128'(rk_valid), 128'(1));
        while (r >= 0 && cyc < 300) begin
            if (mode == 0) rk_ready = 1'b1;
            else if (r == 5 && stall < 8) begin rk_ready = 1'b0; stall++; end
            else rk_ready = 1'($urandom_range(0, 1));
            if (r == start_at && !injected) begin
                start = 1'b1; key_in = ~exp_k[10]; injected = 1'b1;
            end
            if (r == abort_at) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                chk("abort_valid", 128'(rk_valid), 128'(0));
                chk("abort_busy", 128'(busy), 128'(0));
                chk("abort_done", 128'(done), 128'(0));
                step();
                chk("abort_done2", 128'(done), 128'(0));
                return;
            end
            if (r == reset_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_valid", 128'(rk_valid), 128'(0));
                chk("rst_busy", 128'(busy), 128'(0));
                chk("rst_done", 128'(done), 128'(0));
                chk("rst_key", rk_key, 128'(0));
                chk("rst_round", 128'(rk_round), 128'(0));
                chk("rst_genkey", gen_key, 128'(0));
                chk("rst_rcon", 128'(gen_rcon), 128'(0));
                step();
                #2 rst_n = 1'b1;
                step();
                chk("rst_after_valid", 128'(rk_valid), 128'(0));
                chk("rst_after_done", 128'(done), 128'(0));
                return;
            end
            chk("valid", 128'(rk_valid), 128'(1));
            chk("busy", 128'(busy), 128'(1));
            chk("done_low", 128'(done), 128'(0));
            chk($sformatf("key_r%0d", r), rk_key, exp_k[r]);
            chk("round", 128'(rk_round), 128'(r));
            if (k0 == FIPS_K0 && r == 10) chk("fips_r10", rk_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
            if (k0 == FIPS_K0 && r == 9)  chk("fips_r9",  rk_key, 128'hac7766f319fadc2128d12941575c006e);
            fired = rk_ready;
            if (fired) chk($sformatf("rcon_r%0d", r), 128'(gen_rcon), 128'({rc_model(r), 24'h0}));
            step();
            start = 1'b0;
            if (fired) r--;
            cyc++;
        end
        chk("finished", 128'(r < 0), 128'(1));
        chk("done_pulse", 128'(done), 128'(1));
        chk("end_busy", 128'(busy), 128'(0));
        chk("end_valid", 128'(rk_valid), 128'(0));
        if (mode == 0) chk("emit_cycles", 128'(cyc), 128'(11));
        rk_ready = 1'b0;
        step();
        chk("done_once", 128'(done), 128'(0));
        chk("idle_busy", 128'(busy), 128'(0));
    endtask

    initial begin
        logic [127:0] k;
        build_sbox();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; rk_ready = 1'b0; key_in = '0;
        start1 = 1'b0; abort1 = 1'b0; rk_ready1 = 1'b0; key_in1 = '0;
        step();
        step();
        chk("reset_valid", 128'(rk_valid), 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_done", 128'(done), 128'(0));
        chk("reset_key", rk_key, 128'(0));
        chk("reset_round", 128'(rk_round), 128'(0));
        chk("reset_genkey", gen_key, 128'(0));
        chk("reset_rcon", 128'(gen_rcon), 128'(0));
        #3 rst_n = 1'b1;
        step();

        run(FIPS_K0, 0, -1, -1, -1);
        run(rand_key(), 1, -1, -1, -1);
        run(rand_key(), 1, 7, -1, -1);
        run(rand_key(), 0, -1, 4, -1);
        run(rand_key(), 0, -1, -1, -1);
        run(rand_key(), 1, -1, -1, 6);
        run(rand_key(), 0, -1, -1, -1);
        for (int i = 0; i < 3; i++) run(rand_key(), 1, -1, -1, -1);

        // NR=1 instance: only rounds 1 and 0, with rcon 01 on the single real step.
        k = rand_key();
        expand(k);
        rk_ready1 = 1'b1;
        start1 = 1'b1; key_in1 = exp_k[1];
        step();
        start1 = 1'b0;
        chk("nr1_valid1", 128'(rk_valid1), 128'(1));
        chk("nr1_round1", 128'(rk_round1), 128'(1));
        chk("nr1_key1", rk_key1, exp_k[1]);
        chk("nr1_rcon1", 128'(gen_rcon1), 128'(32'h01000000));
        step();
        chk("nr1_valid0", 128'(rk_valid1), 128'(1));
        chk("nr1_round0", 128'(rk_round1), 128'(0));
        chk("nr1_key0", rk_key1, exp_k[0]);
        chk("nr1_rcon0", 128'(gen_rcon1), 128'(0));
        step();
        chk("nr1_done", 128'(done1), 128'(1));
        chk("nr1_busy", 128'(busy1), 128'(0));
        step();
        chk("nr1_done_once", 128'(done1), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
